// File: rtl/spec_free_list.sv
// Speculative physical-register free list for rename: four-wide pop at the head, up to
// four compacted pushes at the tail, single-cycle restore of the head on recovery.
module spec_free_list #(
    parameter int SIZE_PHYSICAL_TABLE = 96,
    parameter int SIZE_RMT            = 32,
    parameter int SIZE_PHYSICAL_LOG   = 7,
    parameter int SIZE_FREE_LIST      = SIZE_PHYSICAL_TABLE - SIZE_RMT,
    parameter int SIZE_FREE_LIST_LOG  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          reqFreeReg_i,
    input  logic                          recoverFlag_i,
    input  logic                          releasedValid0_i,
    input  logic                          releasedValid1_i,
    input  logic                          releasedValid2_i,
    input  logic                          releasedValid3_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap0_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap2_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap3_i,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg0_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg1_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg2_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg3_o,
    output logic                          freeListEmpty_o,
    output logic [SIZE_FREE_LIST_LOG:0]   freeCount_o
);

    typedef logic [SIZE_FREE_LIST_LOG-1:0] ptr_t;
    typedef logic [SIZE_FREE_LIST_LOG:0]   cnt_t;
    typedef logic [SIZE_PHYSICAL_LOG-1:0]  tag_t;

    localparam cnt_t N_CNT = cnt_t'(SIZE_FREE_LIST);

    // Modulo-N add with an explicit subtract, so non-power-of-two depths also wrap correctly.
    function automatic ptr_t wrapAdd(input ptr_t base, input logic [2:0] inc);
        cnt_t sum;
        sum = {1'b0, base} + cnt_t'(inc);
        if (sum >= N_CNT) sum = sum - N_CNT;
        return sum[SIZE_FREE_LIST_LOG-1:0];
    endfunction

    tag_t       list [SIZE_FREE_LIST];
    ptr_t       headPtr;
    ptr_t       archHeadPtr;
    ptr_t       tailPtr;
    cnt_t       freeCnt;

    logic [3:0] relValid;
    tag_t       relTag [4];
    ptr_t       wrSlot [4];
    logic [2:0] rel;
    ptr_t       archNext;
    logic       grant;

    assign relValid  = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
    assign relTag[0] = releasedPhyMap0_i;
    assign relTag[1] = releasedPhyMap1_i;
    assign relTag[2] = releasedPhyMap2_i;
    assign relTag[3] = releasedPhyMap3_i;

    // Each valid release lands at tail plus the number of valid releases older than it.
    always_comb begin
        rel = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wrSlot[i] = wrapAdd(tailPtr, rel);
            rel       = rel + 3'(relValid[i]);
        end
    end

    assign archNext        = wrapAdd(archHeadPtr, rel);
    assign freeListEmpty_o = (freeCnt < cnt_t'(4));
    assign grant           = reqFreeReg_i & ~freeListEmpty_o & ~recoverFlag_i;

    assign freeReg0_o  = list[headPtr];
    assign freeReg1_o  = list[wrapAdd(headPtr, 3'd1)];
    assign freeReg2_o  = list[wrapAdd(headPtr, 3'd2)];
    assign freeReg3_o  = list[wrapAdd(headPtr, 3'd3)];
    assign freeCount_o = freeCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SIZE_FREE_LIST; i++) begin
                list[i] <= tag_t'(SIZE_RMT + i);
            end
            headPtr     <= '0;
            archHeadPtr <= '0;
            tailPtr     <= '0;
            freeCnt     <= N_CNT;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (relValid[i]) list[wrSlot[i]] <= relTag[i];
            end
            tailPtr     <= wrapAdd(tailPtr, rel);
            archHeadPtr <= archNext;
            if (recoverFlag_i) begin
                headPtr <= archNext;
                freeCnt <= N_CNT;
            end else begin
                if (grant) headPtr <= wrapAdd(headPtr, 3'd4);
                freeCnt <= freeCnt + cnt_t'(rel) - (grant ? cnt_t'(4) : cnt_t'(0));
            end
        end
    end

endmodule

// File: doc/spec_free_list.md
# spec_free_list

Speculative physical-register free list for the rename stage. Rename pops four free physical registers per cycle. The architectural map table pushes back up to four released physical registers per cycle at commit. On a mispredict or exception recovery, an architectural head pointer restores the list in one cycle, so every register allocated by a squashed instruction returns to the free pool.

## Interface
Parameters:
- `SIZE_PHYSICAL_TABLE`, default 96: number of physical registers.
- `SIZE_RMT`, default 32: number of logical registers (architecturally mapped at reset).
- `SIZE_PHYSICAL_LOG`, default 7: physical tag width.
- `SIZE_FREE_LIST`, default `SIZE_PHYSICAL_TABLE-SIZE_RMT` (64): ring depth N.
- `SIZE_FREE_LIST_LOG`, default 6: pointer width.

Ports:
- `clk`  in  1: clock. One clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `reqFreeReg_i`  in  1: rename requests four free registers this cycle.
- `recoverFlag_i`  in  1: recovery pulse from the active list.
- `releasedValid0_i`..`releasedValid3_i`  in  1 each: released-register valids. Index 0 is the oldest.
- `releasedPhyMap0_i`..`releasedPhyMap3_i`  in  `SIZE_PHYSICAL_LOG` each: released physical tags.
- `freeReg0_o`..`freeReg3_o`  out  `SIZE_PHYSICAL_LOG` each: tags at head, head+1, head+2, head+3.
- `freeListEmpty_o`  out  1: fewer than four free entries. Rename must stall.
- `freeCount_o`  out  `SIZE_FREE_LIST_LOG+1`: current free count.

## Operation
State:
- Ring `list[0..N-1]`.
- Pointers `headPtr`, `archHeadPtr`, `tailPtr`, each `SIZE_FREE_LIST_LOG` bits.
- `freeCnt`, `SIZE_FREE_LIST_LOG+1` bits.

Reset:
- `list[i] = SIZE_RMT + i`.
- All pointers 0.
- `freeCnt = N`.
- Outputs after reset: `freeReg0..3_o` = 32, 33, 34, 35; `freeListEmpty_o` = 0; `freeCount_o` = 64.

Pointer and ring updates:
- All pointer arithmetic is modulo N. Explicit wrap: when a sum is ≥ N, subtract N.
- `grant = reqFreeReg_i & ~freeListEmpty_o & ~recoverFlag_i`. On grant, `headPtr += 4`.
- `rel = popcount(releasedValid0..3_i)`.
- Valid released tags are compacted in index order and written to `list[tailPtr]`, `list[tailPtr+1]`, and so on. Then `tailPtr += rel`.
- Releases are accepted every cycle, including during recovery.
- Each release corresponds to one committing instruction with a destination, so `archHeadPtr += rel` every cycle.

Free-count update:
- Normal cycle: `freeCnt += rel - 4*grant`.
- Recovery cycle: `headPtr <= archHeadPtr + rel` (the updated arch head) and `freeCnt <= N`. Entries between the arch head and the speculative head are still intact, because the tail can never write past `archHeadPtr`.

Invariants:
- Overflow (`freeCnt + rel > N`) is a protocol violation. The bench asserts on it; the RTL does not guard it.
- Underflow is impossible because grant requires `freeCnt ≥ 4`.
- `freeListEmpty_o = (freeCnt < 4)`, combinational from the register.

## Timing
- Outputs are combinational from registered state; no read latency. `freeReg*_o` is valid in the same cycle as `reqFreeReg_i`.
- An allocation is reflected in head and count on the next cycle.
- A release is allocatable one cycle after it is pushed. Same-cycle bypass to `freeReg*_o` is not provided.
- Simultaneous grant and release: both apply. The read and write slots never alias, because a grant needs ≥ 4 free entries and the write slots lie outside `head..head+3`.
- Recovery takes priority over a request: no grant that cycle, and the list is full-restored the next cycle.
- Reset mid-operation restores the reset state on the next edge, regardless of the other inputs.

## Test plan
- Reset, then idle: `freeReg0..3_o` = 32..35, `freeCount_o` = 64, `freeListEmpty_o` = 0.
- One grant: the next cycle shows `freeReg0..3_o` = 36..39 and count 60. Then release valids {0,1,0,1} with tags 5 and 9: 5 and 9 are written at tail slots 0 and 1, count becomes 62, `archHeadPtr` = 2.
- Sixteen consecutive grants with no releases: count reaches 0 and `freeListEmpty_o` = 1. A further request is ignored, and head and count are unchanged.
- Eight grants, then one cycle releasing 4 tags, then `recoverFlag_i`: the next cycle has count 64 and `headPtr` = 4. `freeReg0..3_o` equals the slots following the committed allocations, i.e. tags 36..39.
- Wrap-around: cycle pointers past index 63 with mixed grants and releases. Tags read back in exact FIFO order, and the count is never off by one across the wrap.
- Grant plus 3 releases in the same cycle: count changes by -1. The same stimulus with `recoverFlag_i` asserted gives count 64 and no grant.
